// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: sequences each instruction through
// fetch/decode/execute/memory/write-back and drives all datapath selects.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       MIO_ready,
    output logic [3:0] ALU_operation,
    output logic [1:0] ALUSrcA,
    output logic [2:0] ALUSrcB,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] PCSource,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       CPU_MIO,
    output logic [4:0] state_out
);

    typedef enum logic [4:0] {
        S_IF       = 5'd0,
        S_ID       = 5'd1,
        S_MEM_ADDR = 5'd2,
        S_MEM_RD   = 5'd3,
        S_LW_WB    = 5'd4,
        S_MEM_WR   = 5'd5,
        S_R_EX     = 5'd6,
        S_R_WB     = 5'd7,
        S_BEQ      = 5'd8,
        S_J        = 5'd9,
        S_I_EX     = 5'd10,
        S_I_WB     = 5'd11,
        S_JAL      = 5'd12,
        S_JR       = 5'd13,
        S_BNE      = 5'd14,
        S_LUI_WB   = 5'd15
    } state_t;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SLL  = 4'd3;
    localparam logic [3:0] ALU_NOR  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_XOR  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_JR  = 6'h08;

    state_t state_q, state_d;

    // R-type funct decode; unknown functs run as add and lose their write-back
    logic [3:0] r_op;
    logic       r_known;
    logic       r_shift;

    always_comb begin
        r_op    = ALU_ADD;
        r_known = 1'b1;
        r_shift = 1'b0;
        case (funct)
            6'h20, 6'h21: r_op = ALU_ADD;
            6'h22, 6'h23: r_op = ALU_SUB;
            6'h24:        r_op = ALU_AND;
            6'h25:        r_op = ALU_OR;
            6'h26:        r_op = ALU_XOR;
            6'h27:        r_op = ALU_NOR;
            6'h2A:        r_op = ALU_SLT;
            6'h2B:        r_op = ALU_SLTU;
            FN_SLL: begin r_op = ALU_SLL; r_shift = 1'b1; end
            FN_SRL: begin r_op = ALU_SRL; r_shift = 1'b1; end
            FN_SRA: begin r_op = ALU_SRA; r_shift = 1'b1; end
            default:      r_known = 1'b0;
        endcase
    end

    // I-type ALU decode; logical immediates are zero-extended
    logic [3:0] i_op;
    logic       i_zext;

    always_comb begin
        i_op   = ALU_ADD;
        i_zext = 1'b0;
        case (opcode)
            OP_ADDI, OP_ADDIU: i_op = ALU_ADD;
            OP_SLTI:           i_op = ALU_SLT;
            OP_SLTIU:          i_op = ALU_SLTU;
            OP_ANDI: begin i_op = ALU_AND; i_zext = 1'b1; end
            OP_ORI:  begin i_op = ALU_OR;  i_zext = 1'b1; end
            OP_XORI: begin i_op = ALU_XOR; i_zext = 1'b1; end
            default:           i_op = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IF;
        else        state_q <= state_d;
    end

    assign state_out = state_q;

    always_comb begin
        state_d       = S_IF;
        ALU_operation = ALU_AND;
        ALUSrcA       = 2'd0;
        ALUSrcB       = 3'd0;
        RegDst        = 2'd0;
        MemtoReg      = 2'd0;
        PCSource      = 2'd0;
        PCWrite       = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        CPU_MIO       = 1'b0;

        case (state_q)
            S_IF: begin
                MemRead       = 1'b1;
                CPU_MIO       = 1'b1;
                ALUSrcB       = 3'd1;
                ALU_operation = ALU_ADD;
                IRWrite       = MIO_ready;
                PCWrite       = MIO_ready;
                state_d       = MIO_ready ? S_ID : S_IF;
            end
            S_ID: begin
                // Speculative branch target lands in ALUOut
                ALUSrcB       = 3'd3;
                ALU_operation = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = (funct == FN_JR) ? S_JR : S_R_EX;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_BNE:       state_d = S_BNE;
                    OP_J:         state_d = S_J;
                    OP_JAL:       state_d = S_JAL;
                    OP_LUI:       state_d = S_LUI_WB;
                    OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                    OP_ANDI, OP_ORI, OP_XORI: state_d = S_I_EX;
                    default:      state_d = S_IF;
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA       = 2'd1;
                ALUSrcB       = 3'd2;
                ALU_operation = ALU_ADD;
                if (opcode == OP_LW)      state_d = S_MEM_RD;
                else if (opcode == OP_SW) state_d = S_MEM_WR;
                else                      state_d = S_IF;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                CPU_MIO = 1'b1;
                IorD    = 1'b1;
                state_d = MIO_ready ? S_LW_WB : S_MEM_RD;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                CPU_MIO  = 1'b1;
                IorD     = 1'b1;
                state_d  = MIO_ready ? S_IF : S_MEM_WR;
            end
            S_LW_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'd1;
                state_d  = S_IF;
            end
            S_R_EX: begin
                ALUSrcA       = r_shift ? 2'd2 : 2'd1;
                ALUSrcB       = r_shift ? 3'd5 : 3'd0;
                ALU_operation = r_op;
                state_d       = S_R_WB;
            end
            S_R_WB: begin
                RegWrite = r_known;
                RegDst   = 2'd1;
                state_d  = S_IF;
            end
            S_I_EX: begin
                ALUSrcA       = 2'd1;
                ALUSrcB       = i_zext ? 3'd4 : 3'd2;
                ALU_operation = i_op;
                state_d       = S_I_WB;
            end
            S_I_WB: begin
                RegWrite = 1'b1;
                state_d  = S_IF;
            end
            S_BEQ, S_BNE: begin
                ALUSrcA       = 2'd1;
                ALU_operation = ALU_SUB;
                PCSource      = 2'd1;
                PCWrite       = (state_q == S_BEQ) ? zero : ~zero;
                state_d       = S_IF;
            end
            S_J: begin
                PCSource = 2'd2;
                PCWrite  = 1'b1;
                state_d  = S_IF;
            end
            S_JAL: begin
                // PC already advanced in IF, so the link value is PC itself
                PCSource = 2'd2;
                PCWrite  = 1'b1;
                RegWrite = 1'b1;
                RegDst   = 2'd2;
                MemtoReg = 2'd2;
                state_d  = S_IF;
            end
            S_JR: begin
                PCSource = 2'd3;
                PCWrite  = 1'b1;
                state_d  = S_IF;
            end
            S_LUI_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'd3;
                state_d  = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks instruction classes and checks states/outputs.
module tb_mc_ctrl;
    logic       clk, rst_n;
    logic [5:0] opcode, funct;
    logic       zero, MIO_ready;
    logic [3:0] ALU_operation;
    logic [1:0] ALUSrcA, RegDst, MemtoReg, PCSource;
    logic [2:0] ALUSrcB;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, CPU_MIO;
    logic [4:0] state_out;

    int checks = 0;
    int failures = 0;

    mc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .MIO_ready(MIO_ready), .ALU_operation(ALU_operation), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .RegDst(RegDst), .MemtoReg(MemtoReg), .PCSource(PCSource),
        .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .CPU_MIO(CPU_MIO), .state_out(state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; opcode = 6'h00; funct = 6'h20; zero = 1'b0; MIO_ready = 1'b1;
        #7;
        chk("rst_state", state_out, 0);
        chk("rst_memread", MemRead, 1);
        chk("rst_irwrite", IRWrite, 1);
        chk("rst_alusrcb", ALUSrcB, 1);
        chk("rst_aluop", ALU_operation, 2);
        MIO_ready = 1'b0; #1;
        chk("rst_pcwrite_mio0", PCWrite, 0);
        MIO_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;

        // add: 0,1,6,7,0
        tick(); chk("add_id", state_out, 1);
        chk("add_id_srcb", ALUSrcB, 3);
        tick(); chk("add_rex", state_out, 6);
        chk("add_rex_op", ALU_operation, 2);
        chk("add_rex_srca", ALUSrcA, 1);
        chk("add_rex_srcb", ALUSrcB, 0);
        chk("add_rex_regwrite", RegWrite, 0);
        tick(); chk("add_rwb", state_out, 7);
        chk("add_rwb_regwrite", RegWrite, 1);
        chk("add_rwb_regdst", RegDst, 1);
        tick(); chk("add_done", state_out, 0);

        // IF wait-state
        MIO_ready = 1'b0;
        tick(); chk("if_wait", state_out, 0);
        chk("if_wait_irwrite", IRWrite, 0);
        MIO_ready = 1'b1;

        // sll, then async reset mid-R_EX
        funct = 6'h00;
        tick(); tick(); chk("sll_rex", state_out, 6);
        chk("sll_op", ALU_operation, 3);
        chk("sll_srca", ALUSrcA, 2);
        chk("sll_srcb", ALUSrcB, 5);
        rst_n = 1'b0; #1;
        chk("midrst_state", state_out, 0);
        chk("midrst_regwrite", RegWrite, 0);
        #1 rst_n = 1'b1;
        tick(); chk("post_rst_id", state_out, 1);
        tick(); tick(); tick(); chk("sll_back_if", state_out, 0);

        // lw with 2 wait cycles in MEM_RD
        opcode = 6'h23;
        tick(); chk("lw_id", state_out, 1);
        tick(); chk("lw_maddr", state_out, 2);
        chk("lw_maddr_srca", ALUSrcA, 1);
        chk("lw_maddr_srcb", ALUSrcB, 2);
        MIO_ready = 1'b0;
        tick(); chk("lw_rd0", state_out, 3);
        chk("lw_rd0_memread", MemRead, 1);
        chk("lw_rd0_iord", IorD, 1);
        tick(); chk("lw_rd1", state_out, 3);
        chk("lw_rd1_iord", IorD, 1);
        tick(); chk("lw_rd2", state_out, 3);
        chk("lw_rd2_memread", MemRead, 1);
        MIO_ready = 1'b1;
        tick(); chk("lw_wb", state_out, 4);
        chk("lw_wb_regwrite", RegWrite, 1);
        chk("lw_wb_memtoreg", MemtoReg, 1);
        tick(); chk("lw_done", state_out, 0);

        // sw
        opcode = 6'h2B;
        tick(); tick(); tick(); chk("sw_mwr", state_out, 5);
        chk("sw_memwrite", MemWrite, 1);
        tick(); chk("sw_done", state_out, 0);

        // beq
        opcode = 6'h04; zero = 1'b1;
        tick(); tick(); chk("beq_state", state_out, 8);
        chk("beq_z1_pcwrite", PCWrite, 1);
        chk("beq_pcsource", PCSource, 1);
        chk("beq_op", ALU_operation, 6);
        zero = 1'b0; #1;
        chk("beq_z0_pcwrite", PCWrite, 0);
        tick(); chk("beq_done", state_out, 0);

        // bne
        opcode = 6'h05; zero = 1'b1;
        tick(); tick(); chk("bne_state", state_out, 14);
        chk("bne_z1_pcwrite", PCWrite, 0);
        zero = 1'b0; #1;
        chk("bne_z0_pcwrite", PCWrite, 1);
        tick(); chk("bne_done", state_out, 0);

        // jal
        opcode = 6'h03;
        tick(); tick(); chk("jal_state", state_out, 12);
        chk("jal_regdst", RegDst, 2);
        chk("jal_memtoreg", MemtoReg, 2);
        chk("jal_pcsource", PCSource, 2);
        chk("jal_pcwrite", PCWrite, 1);
        tick();

        // jr
        opcode = 6'h00; funct = 6'h08;
        tick(); tick(); chk("jr_state", state_out, 13);
        chk("jr_pcsource", PCSource, 3);
        tick();

        // lui
        opcode = 6'h0F;
        tick(); tick(); chk("lui_state", state_out, 15);
        chk("lui_memtoreg", MemtoReg, 3);
        chk("lui_regwrite", RegWrite, 1);
        tick();

        // ori
        opcode = 6'h0D;
        tick(); tick(); chk("ori_state", state_out, 10);
        chk("ori_srcb", ALUSrcB, 4);
        chk("ori_op", ALU_operation, 1);
        tick(); chk("ori_wb", state_out, 11);
        chk("ori_wb_regwrite", RegWrite, 1);
        tick();

        // unknown R funct: write suppressed
        opcode = 6'h00; funct = 6'h3F;
        tick(); tick(); chk("unk_rex_op", ALU_operation, 2);
        tick(); chk("unk_rwb", state_out, 7);
        chk("unk_rwb_regwrite", RegWrite, 0);
        tick();

        // undefined opcode -> nop
        opcode = 6'h3F;
        tick(); chk("bad_id", state_out, 1);
        chk("bad_id_pcwrite", PCWrite, 0);
        chk("bad_id_regwrite", RegWrite, 0);
        chk("bad_id_memwrite", MemWrite, 0);
        tick(); chk("bad_back_if", state_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
